port_ext_pipe: RTL and testbench

- Multi-channel registered width adapter that converts NCH lanes from IN_W to OUT_W bits per beat.
- Conversion modes, selectable per lane and per beat: zero-extend, sign-extend, unsigned saturate, signed saturate.
- Valid/ready handshake with a 2-entry skid buffer, so full throughput is held under backpressure.
- Sits between port-facing producers and consumers of differing widths; replaces ad-hoc continuous-assign extension at module boundaries.

---
 rtl/port_ext_pkg.sv | 21 ++
 rtl/port_ext_pipe_lane.sv | 68 ++++++
 rtl/port_ext_pipe.sv | 99 +++++++++
 tb/tb_port_ext_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : port_ext_pkg
// Brief    : Shared mode encoding and skid-buffer constants for port_ext_pipe.
// Revision : 1.0  initial release
// ============================================================================
package port_ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZEXT = 2'b00,
    EXT_SEXT = 2'b01,
    EXT_USAT = 2'b10,
    EXT_SSAT = 2'b11
  } ext_mode_t;

  localparam int c_skid_depth = 2;
  localparam int c_main_idx   = 0;
  localparam int c_skid_idx   = 1;

endpackage
`default_nettype wire

// File: rtl/port_ext_pipe_lane.sv
`default_nettype none
// ============================================================================
// Module   : port_ext_lane
// Brief    : Combinational single-lane width conversion with saturation flag.
// Revision : 1.0  initial release
// ============================================================================
module port_ext_lane
  import port_ext_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  if (OUT_W < IN_W) begin : g_narrow
    localparam logic [OUT_W-1:0] c_smin = OUT_W'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0] c_smax = ~c_smin;

    logic [OUT_W-1:0] w_low;
    logic             w_drop_u;
    logic             w_fit_s;

    assign w_low    = din[OUT_W-1:0];
    assign w_drop_u = |din[IN_W-1:OUT_W];
    // A signed value fits when every bit from the new sign position up agrees.
    assign w_fit_s  = (&din[IN_W-1:OUT_W-1]) | ~(|din[IN_W-1:OUT_W-1]);

    always_comb begin
      dout = w_low;
      sat  = 1'b0;
      case (mode)
        EXT_USAT: begin
          if (w_drop_u) begin
            dout = '1;
            sat  = 1'b1;
          end
        end
        EXT_SSAT: begin
          if (!w_fit_s) begin
            dout = din[IN_W-1] ? c_smin : c_smax;
            sat  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end else begin : g_wide
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;

    assign w_zext = OUT_W'(din);
    assign w_sext = OUT_W'($signed(din));

    always_comb begin
      dout = w_zext;
      sat  = 1'b0;
      if (mode == EXT_SEXT || mode == EXT_SSAT) begin
        dout = w_sext;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : port_ext_pipe
// Brief    : NCH-lane registered width adapter with 2-entry skid buffer and
//            saturating saturation-event counter.
// Revision : 1.0  initial release
// ============================================================================
module port_ext_pipe
  import port_ext_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*IN_W-1:0]  in_data,
  input  logic [NCH*2-1:0]     in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*OUT_W-1:0] out_data,
  output logic [NCH-1:0]       out_sat,
  output logic [CNT_W-1:0]     sat_cnt,
  input  logic                 clr_cnt
);

  logic [NCH*OUT_W-1:0] w_conv_data;
  logic [NCH-1:0]       w_conv_sat;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    port_ext_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .din  (in_data[i*IN_W +: IN_W]),
      .mode (ext_mode_t'(in_mode[2*i +: 2])),
      .dout (w_conv_data[i*OUT_W +: OUT_W]),
      .sat  (w_conv_sat[i])
    );
  end

  logic [NCH*OUT_W-1:0]    r_data [c_skid_depth];
  logic [NCH-1:0]          r_sat  [c_skid_depth];
  logic [c_skid_depth-1:0] r_vld;
  logic [CNT_W-1:0]        r_cnt;

  logic w_accept;
  logic w_adv;

  assign w_accept = in_valid & in_ready;
  // Main entry may be overwritten when it is empty or being consumed.
  assign w_adv    = ~r_vld[c_main_idx] | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < c_skid_depth; k++) begin
        r_data[k] <= '0;
        r_sat[k]  <= '0;
      end
    end else if (w_adv) begin
      if (r_vld[c_skid_idx]) begin
        r_data[c_main_idx] <= r_data[c_skid_idx];
        r_sat[c_main_idx]  <= r_sat[c_skid_idx];
        r_vld[c_main_idx]  <= 1'b1;
        r_vld[c_skid_idx]  <= 1'b0;
      end else begin
        r_vld[c_main_idx] <= w_accept;
        if (w_accept) begin
          r_data[c_main_idx] <= w_conv_data;
          r_sat[c_main_idx]  <= w_conv_sat;
        end
      end
    end else if (w_accept) begin
      r_data[c_skid_idx] <= w_conv_data;
      r_sat[c_skid_idx]  <= w_conv_sat;
      r_vld[c_skid_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_cnt <= '0;
    end else if (w_accept && (|w_conv_sat) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = ~r_vld[c_skid_idx] & ~rst;
  assign out_valid = r_vld[c_main_idx];
  assign out_data  = r_data[c_main_idx];
  assign out_sat   = r_sat[c_main_idx];
  assign sat_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_port_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_ext_pipe
// Brief    : Scoreboard bench for wide, narrowing and equal-width instances.
// Revision : 1.0  initial release
// ============================================================================
module tb_port_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_clr;
  logic [7:0]  d_in_data;
  logic [3:0]  d_in_mode;
  logic [15:0] d_out_data;
  logic [1:0]  d_out_sat;
  logic [7:0]  d_cnt;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_clr;
  logic [7:0]  n_in_data;
  logic [1:0]  n_in_mode;
  logic [3:0]  n_out_data;
  logic [0:0]  n_out_sat;
  logic [1:0]  n_cnt;

  logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_clr;
  logic [3:0]  e_in_data;
  logic [1:0]  e_in_mode;
  logic [3:0]  e_out_data;
  logic [0:0]  e_out_sat;
  logic [7:0]  e_cnt;

  port_ext_pipe #(.NCH(2), .IN_W(4), .OUT_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .in_mode(d_in_mode), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_data(d_out_data), .out_sat(d_out_sat),
    .sat_cnt(d_cnt), .clr_cnt(d_clr)
  );

  port_ext_pipe #(.NCH(1), .IN_W(8), .OUT_W(4), .CNT_W(2)) u_nar (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .in_mode(n_in_mode), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .out_data(n_out_data), .out_sat(n_out_sat),
    .sat_cnt(n_cnt), .clr_cnt(n_clr)
  );

  port_ext_pipe #(.NCH(1), .IN_W(4), .OUT_W(4), .CNT_W(8)) u_eq (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_data(e_in_data), .in_mode(e_in_mode), .out_valid(e_out_valid),
    .out_ready(e_out_ready), .out_data(e_out_data), .out_sat(e_out_sat),
    .sat_cnt(e_cnt), .clr_cnt(e_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [17:0] q_d[$];
  logic [4:0]  q_n[$];
  logic [4:0]  q_e[$];

  // Reference for the widening instance: low mode bit selects sign extension.
  function automatic logic [17:0] model_d(input logic [7:0] data, input logic [3:0] mode);
    logic [15:0] res;
    logic [3:0]  v;
    logic [1:0]  m;
    res = '0;
    for (int l = 0; l < 2; l++) begin
      v = data[4*l +: 4];
      m = mode[2*l +: 2];
      res[8*l +: 8] = m[0] ? {{4{v[3]}}, v} : {4'h0, v};
    end
    return {2'b00, res};
  endfunction

  logic [16:0] prev_d;
  logic        prev_stall;
  logic [17:0] ed;
  logic [4:0]  en;
  logic [4:0]  ee;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) chk("d_hold", 32'({d_out_valid, d_out_data}), 32'({1'b1, prev_d[15:0]}));
      if (d_out_valid && d_out_ready) begin
        chk("d_sb_nonempty", 32'(q_d.size() != 0), 32'd1);
        if (q_d.size() != 0) begin
          ed = q_d.pop_front();
          chk("d_data", 32'({d_out_sat, d_out_data}), 32'(ed));
        end
      end
      if (d_in_valid && d_in_ready) q_d.push_back(model_d(d_in_data, d_in_mode));
      prev_stall = d_out_valid & ~d_out_ready;
      prev_d     = {1'b0, d_out_data};

      if (n_out_valid && n_out_ready) begin
        chk("n_sb_nonempty", 32'(q_n.size() != 0), 32'd1);
        if (q_n.size() != 0) begin
          en = q_n.pop_front();
          chk("n_data", 32'({n_out_sat, n_out_data}), 32'(en));
        end
      end
      if (e_out_valid && e_out_ready) begin
        chk("e_sb_nonempty", 32'(q_e.size() != 0), 32'd1);
        if (q_e.size() != 0) begin
          ee = q_e.pop_front();
          chk("e_data", 32'({e_out_sat, e_out_data}), 32'(ee));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic d_send(input logic [7:0] data, input logic [3:0] mode);
    logic acc;
    int   guard;
    d_in_valid = 1'b1;
    d_in_data  = data;
    d_in_mode  = mode;
    guard      = 0;
    acc        = 1'b0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = d_in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk("d_send_timeout", 32'(guard), 32'd0);
    d_in_valid = 1'b0;
  endtask

  task automatic n_send(input logic [7:0] data, input logic [1:0] mode,
                        input logic [3:0] exp_data, input logic exp_sat,
                        input logic [1:0] exp_cnt, input logic clr);
    n_in_valid = 1'b1;
    n_in_data  = data;
    n_in_mode  = mode;
    n_clr      = clr;
    q_n.push_back({exp_sat, exp_data});
    @(negedge clk);
    chk("n_in_ready", 32'(n_in_ready), 32'd1);
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    n_clr      = 1'b0;
    chk("n_out_valid", 32'(n_out_valid), 32'd1);
    chk("n_sat_cnt", 32'(n_cnt), 32'(exp_cnt));
  endtask

  task automatic e_send(input logic [3:0] data, input logic [1:0] mode);
    e_in_valid = 1'b1;
    e_in_data  = data;
    e_in_mode  = mode;
    q_e.push_back({1'b0, 4'h9});
    @(posedge clk);
    #1;
    e_in_valid = 1'b0;
    chk("e_out_valid", 32'(e_out_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] bp_beats [4];
  int         idx;
  int         acc_cnt;
  logic       acc;
  bit         done;

  initial begin
    rst = 1'b1;
    prev_stall = 1'b0;
    prev_d = '0;
    d_in_valid = 0; d_out_ready = 1; d_clr = 0; d_in_data = 0; d_in_mode = 0;
    n_in_valid = 0; n_out_ready = 1; n_clr = 0; n_in_data = 0; n_in_mode = 0;
    e_in_valid = 0; e_out_ready = 1; e_clr = 0; e_in_data = 0; e_in_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 32'(d_in_ready), 32'd0);
    chk("rst_out_valid", 32'(d_out_valid), 32'd0);
    chk("rst_out_data", 32'(d_out_data), 32'd0);
    chk("rst_out_sat", 32'(d_out_sat), 32'd0);
    chk("rst_sat_cnt", 32'(d_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(d_in_ready), 32'd1);

    // Directed mixed-mode beat on the widening instance.
    d_in_valid = 1'b1; d_in_data = 8'hAA; d_in_mode = 4'b00_01;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    chk("d_latency_valid", 32'(d_out_valid), 32'd1);
    chk("d_tp_data", 32'(d_out_data), 32'h0AFA);
    chk("d_tp_sat", 32'(d_out_sat), 32'd0);

    // Random stream with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) d_send(8'($urandom), 4'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          d_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    d_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("d_drain", 32'(q_d.size()), 32'd0);

    // Backpressure: 3 stalled cycles with beats offered continuously.
    bp_beats[0] = 8'h11; bp_beats[1] = 8'h22; bp_beats[2] = 8'h33; bp_beats[3] = 8'h44;
    d_out_ready = 1'b0;
    idx = 0; acc_cnt = 0;
    d_in_mode = 4'b0000;
    d_in_valid = 1'b1; d_in_data = bp_beats[0];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      acc = d_in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cnt++;
        idx++;
        d_in_data = bp_beats[idx];
      end
    end
    chk("bp_accepted", 32'(acc_cnt), 32'd2);
    chk("bp_in_ready", 32'(d_in_ready), 32'd0);
    d_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_nogap", 32'(d_out_valid), 32'd1);
      acc = d_in_valid & d_in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) d_in_data = bp_beats[idx];
        else d_in_valid = 1'b0;
      end
    end
    chk("bp_all_sent", 32'(idx), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_drain", 32'(q_d.size()), 32'd0);

    // Narrowing instance: saturation modes and counter (CNT_W=2).
    n_send(8'h7F, 2'b11, 4'h7, 1'b1, 2'd1, 1'b0);
    n_send(8'h80, 2'b11, 4'h8, 1'b1, 2'd2, 1'b0);
    n_send(8'hF9, 2'b11, 4'h9, 1'b0, 2'd2, 1'b0);
    n_send(8'h12, 2'b10, 4'hF, 1'b1, 2'd3, 1'b0);
    n_send(8'h12, 2'b00, 4'h2, 1'b0, 2'd3, 1'b0);
    n_clr = 1'b1;
    @(posedge clk);
    #1;
    n_clr = 1'b0;
    chk("n_clr", 32'(n_cnt), 32'd0);
    n_send(8'h7F, 2'b11, 4'h7, 1'b1, 2'd1, 1'b0);
    n_send(8'h7F, 2'b11, 4'h7, 1'b1, 2'd2, 1'b0);
    n_send(8'h7F, 2'b11, 4'h7, 1'b1, 2'd3, 1'b0);
    n_send(8'h7F, 2'b11, 4'h7, 1'b1, 2'd3, 1'b0);
    n_send(8'h7F, 2'b11, 4'h7, 1'b1, 2'd3, 1'b0);
    n_send(8'h80, 2'b11, 4'h8, 1'b1, 2'd0, 1'b1);
    n_send(8'h80, 2'b11, 4'h8, 1'b1, 2'd1, 1'b0);

    // Equal widths: every mode passes the value through unflagged.
    for (int m = 0; m < 4; m++) e_send(4'h9, 2'(m));
    repeat (2) @(posedge clk);
    #1;
    chk("n_drain", 32'(q_n.size()), 32'd0);
    chk("e_drain", 32'(q_e.size()), 32'd0);

    // Reset with both skid entries full.
    d_out_ready = 1'b0;
    d_send(8'h5C, 4'b0101);
    d_send(8'hC5, 4'b1111);
    chk("mid_skid_full", 32'(d_in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_out_valid", 32'(d_out_valid), 32'd0);
    chk("mid_d_cnt", 32'(d_cnt), 32'd0);
    chk("mid_n_cnt", 32'(n_cnt), 32'd0);
    chk("mid_in_ready_rst", 32'(d_in_ready), 32'd0);
    q_d.delete();
    rst = 1'b0;
    d_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_in_ready_rel", 32'(d_in_ready), 32'd1);
    d_in_valid = 1'b1; d_in_data = 8'h3C; d_in_mode = 4'b0001;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    chk("mid_latency_valid", 32'(d_out_valid), 32'd1);
    chk("mid_data", 32'(d_out_data), 32'h03FC);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_drain", 32'(q_d.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
